complex_mult_pipe: RTL

Pipelined, parametrised complex multiplier. Successor to the team's combinational three-multiplier complex multiply. Computes (a_i + j·a_q)·(b_i ± j·b_q) with the 3-multiplier Gauss decomposition. Adds:
- valid/ready streaming with backpressure
- a per-sample conjugate-B mode
- selectable output scaling with round-half-up and saturation

Sits between the mixer/NCO path and the filter chain in DSP datapaths.

---
 rtl/complex_mult_pkg.sv | 32 +++
 rtl/round_sat.sv | 78 +++++++
 rtl/complex_mult_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/complex_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : complex_mult_pkg
//  Description : Shared constants and helpers for the pipelined complex
//                multiplier: full-precision width, saturation limits and
//                pipeline latency.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package complex_mult_pkg;

  // Number of register stages between an accepted input and out_valid.
  localparam int PIPE_LAT = 3;

  // Full-precision width of a Gauss-decomposed complex product. The +2 covers
  // the sign-extended pre-sum and the exact negation of the most negative B.
  function automatic int full_width(input int dina_w, input int dinb_w);
    return dina_w + dinb_w + 2;
  endfunction

  // Largest positive value representable in a signed w-bit word.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in a signed w-bit word.
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : round_sat
//  Description : Combinational scaler. Optionally adds half an LSB of the
//                target scale, arithmetic-shifts right by SHIFT and clips the
//                result to a signed DOUT_WIDTH word.
//  Ports       : din  - full-precision signed input (FULL_W bits)
//                dout - scaled, saturated signed output (DOUT_WIDTH bits)
//                sat  - high when dout was clipped
//  Revision    : 1.0 - initial release
// ============================================================================
module round_sat
  import complex_mult_pkg::*;
#(
  parameter int FULL_W     = 34,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 15,
  parameter int ROUND_EN   = 1
) (
  input  logic signed [FULL_W-1:0]     din,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat
);

  // One guard bit so the rounding constant can never wrap the sum.
  localparam int EXT_W = FULL_W + 1;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;

  assign ext = {din[FULL_W-1], din};

  generate
    if (ROUND_EN != 0 && SHIFT > 0) begin : g_round
      localparam logic signed [EXT_W-1:0] HALF = {{(EXT_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign biased = ext + HALF;
    end else begin : g_trunc
      assign biased = ext;
    end
  endgenerate

  // Arithmetic shift gives floor(); combined with the half-LSB bias this is
  // round-half-up.
  assign shifted = biased >>> SHIFT;

  generate
    if (DOUT_WIDTH >= EXT_W) begin : g_nosat
      assign dout = DOUT_WIDTH'(shifted);
      assign sat  = 1'b0;
    end else begin : g_sat
      localparam logic signed [DOUT_WIDTH-1:0] MAX_V = DOUT_WIDTH'(sat_max(DOUT_WIDTH));
      localparam logic signed [DOUT_WIDTH-1:0] MIN_V = DOUT_WIDTH'(sat_min(DOUT_WIDTH));

      // The value fits iff every bit from the output sign bit upward equals
      // the input sign bit.
      logic [EXT_W-DOUT_WIDTH:0] top_bits;
      logic                      pos_ovf;
      logic                      neg_ovf;

      assign top_bits = shifted[EXT_W-1:DOUT_WIDTH-1];
      assign pos_ovf  = !shifted[EXT_W-1] && (|top_bits);
      assign neg_ovf  =  shifted[EXT_W-1] && !(&top_bits);

      always_comb begin
        dout = shifted[DOUT_WIDTH-1:0];
        if (pos_ovf) begin
          dout = MAX_V;
        end else if (neg_ovf) begin
          dout = MIN_V;
        end
        sat = pos_ovf | neg_ovf;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/complex_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : complex_mult_pipe
//  Description : Three-stage pipelined complex multiplier using the
//                3-multiplier Gauss decomposition, with optional conjugation
//                of B, valid/ready backpressure and rounded, saturated output
//                scaling.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                in_valid/in_ready - input handshake
//                conj_b            - use conj(B) for this sample
//                dina_i/dina_q     - operand A (signed, DINA_WIDTH)
//                dinb_i/dinb_q     - operand B (signed, DINB_WIDTH)
//                out_valid/out_ready - output handshake
//                mult_i/mult_q     - scaled product (signed, DOUT_WIDTH)
//                sat_flag          - either component clipped
//  Revision    : 1.0 - initial release
// ============================================================================
module complex_mult_pipe
  import complex_mult_pkg::*;
#(
  parameter int DINA_WIDTH = 16,
  parameter int DINB_WIDTH = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 15,
  parameter int ROUND_EN   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         conj_b,
  input  logic signed [DINA_WIDTH-1:0] dina_i,
  input  logic signed [DINA_WIDTH-1:0] dina_q,
  input  logic signed [DINB_WIDTH-1:0] dinb_i,
  input  logic signed [DINB_WIDTH-1:0] dinb_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] mult_i,
  output logic signed [DOUT_WIDTH-1:0] mult_q,
  output logic                         sat_flag
);

  localparam int FULL_W = full_width(DINA_WIDTH, DINB_WIDTH);
  localparam int DA     = DINA_WIDTH;
  localparam int DB     = DINB_WIDTH;

  // --------------------------------------------------------------------------
  // Handshake: one global enable stalls every stage together, so the only
  // path into in_ready is from out_ready and the registered out_valid.
  // --------------------------------------------------------------------------
  logic                en;
  logic [PIPE_LAT-1:0] vld;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld[PIPE_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[PIPE_LAT-2:0], in_valid};
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: conditional conjugate and pre-sums
  // --------------------------------------------------------------------------
  // bq' gets one extra bit so that negating the most negative B is exact.
  logic signed [DB:0]   bq_ext;
  logic signed [DB:0]   bq_conj;
  logic signed [DB+1:0] sb_c;
  logic signed [DA:0]   sa_c;
  logic signed [DA:0]   da_c;

  assign bq_ext  = {dinb_q[DB-1], dinb_q};
  assign bq_conj = conj_b ? -bq_ext : bq_ext;
  assign sb_c    = {{2{dinb_i[DB-1]}}, dinb_i} + {bq_conj[DB], bq_conj};
  assign sa_c    = {dina_i[DA-1], dina_i} + {dina_q[DA-1], dina_q};
  assign da_c    = {dina_i[DA-1], dina_i} - {dina_q[DA-1], dina_q};

  logic signed [DA-1:0] ai_s1;
  logic signed [DB-1:0] bi_s1;
  logic signed [DB:0]   bq_s1;
  logic signed [DB+1:0] sb_s1;
  logic signed [DA:0]   sa_s1;
  logic signed [DA:0]   da_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ai_s1 <= '0;
      bi_s1 <= '0;
      bq_s1 <= '0;
      sb_s1 <= '0;
      sa_s1 <= '0;
      da_s1 <= '0;
    end else if (en && in_valid) begin
      ai_s1 <= dina_i;
      bi_s1 <= dinb_i;
      bq_s1 <= bq_conj;
      sb_s1 <= sb_c;
      sa_s1 <= sa_c;
      da_s1 <= da_c;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: three products
  //   real = pa - pb, imag = pa - pc
  // --------------------------------------------------------------------------
  logic signed [FULL_W-1:0] pa_s2;
  logic signed [FULL_W-1:0] pb_s2;
  logic signed [FULL_W-1:0] pc_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_s2 <= '0;
      pb_s2 <= '0;
      pc_s2 <= '0;
    end else if (en && vld[0]) begin
      pa_s2 <= FULL_W'(ai_s1) * FULL_W'(sb_s1);
      pb_s2 <= FULL_W'(bq_s1) * FULL_W'(sa_s1);
      pc_s2 <= FULL_W'(bi_s1) * FULL_W'(da_s1);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: recombine, scale, saturate and register the outputs
  // --------------------------------------------------------------------------
  // The true results are bounded by 2^(DA+DB-1) in magnitude, so the FULL_W
  // differences cannot wrap.
  logic signed [FULL_W-1:0]     real_full;
  logic signed [FULL_W-1:0]     imag_full;
  logic signed [DOUT_WIDTH-1:0] real_sc;
  logic signed [DOUT_WIDTH-1:0] imag_sc;
  logic                         real_sat;
  logic                         imag_sat;

  assign real_full = pa_s2 - pb_s2;
  assign imag_full = pa_s2 - pc_s2;

  round_sat #(
    .FULL_W     (FULL_W),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SHIFT      (SHIFT),
    .ROUND_EN   (ROUND_EN)
  ) u_rs_real (
    .din  (real_full),
    .dout (real_sc),
    .sat  (real_sat)
  );

  round_sat #(
    .FULL_W     (FULL_W),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SHIFT      (SHIFT),
    .ROUND_EN   (ROUND_EN)
  ) u_rs_imag (
    .din  (imag_full),
    .dout (imag_sc),
    .sat  (imag_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_i   <= '0;
      mult_q   <= '0;
      sat_flag <= 1'b0;
    end else if (en && vld[1]) begin
      mult_i   <= real_sc;
      mult_q   <= imag_sc;
      sat_flag <= real_sat | imag_sat;
    end
  end

endmodule
`default_nettype wire
